// File: rtl/neuron_pkg.sv
// Shared constants and FSM state encoding for the neuron sequencer.
package neuron_pkg;

   localparam int ACC_W  = 20;            // accumulator width (signed)
   localparam int DATA_W = 8;             // x, weight, bias and y width (signed)
   localparam int PROD_W = 2 * DATA_W;    // full signed product width

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      FINISH,
      OUT
   } state_t;

endpackage

// File: rtl/round_sat_relu.sv
// Combinational output stage: round half up, arithmetic shift, saturate to
// the 8-bit signed range, then optional ReLU.
module round_sat_relu
   import neuron_pkg::*;
#(
   parameter int SHIFT = 6
) (
   input  logic signed [ACC_W-1:0]  i_acc,
   input  logic                     i_relu,
   output logic signed [DATA_W-1:0] o_y
);

   // One extra bit so adding the rounding constant can never wrap.
   localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1) << (SHIFT - 1);
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(127);
   localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-128);

   logic signed [ACC_W:0] w_sum;
   logic signed [ACC_W:0] w_shift;

   // Round, shift, clamp, then clip negatives when ReLU is on.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path through the if/else chain can leave it unassigned (latch).
      o_y     = '0;
      w_sum   = {i_acc[ACC_W-1], i_acc} + HALF;
      w_shift = w_sum >>> SHIFT;
      if (w_shift > SAT_MAX) begin
         o_y = SAT_MAX[DATA_W-1:0];
      end else if (w_shift < SAT_MIN) begin
         o_y = SAT_MIN[DATA_W-1:0];
      end else begin
         o_y = w_shift[DATA_W-1:0];
      end
      if (i_relu && w_shift[ACC_W]) begin
         o_y = '0;
      end
   end

endmodule

// File: rtl/neuron_seq.sv
// Single neuron evaluated sequentially: bias plus N_IN streamed
// multiply-accumulates, then round/saturate/ReLU into a one-entry result.
module neuron_seq
   import neuron_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int SHIFT = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [2:0]               cfg_addr,
   input  logic signed [DATA_W-1:0] cfg_wdata,
   input  logic                     bias_we,
   input  logic signed [DATA_W-1:0] bias_wdata,
   input  logic                     relu_en,
   input  logic                     start,
   output logic                     busy,
   input  logic                     x_valid,
   output logic                     x_ready,
   input  logic signed [DATA_W-1:0] x_data,
   output logic                     y_valid,
   input  logic                     y_ready,
   output logic signed [DATA_W-1:0] y_data
);

   localparam int CNT_W = 4;
   localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

   state_t                   r_state;
   state_t                   w_next_state;
   logic signed [DATA_W-1:0] r_weights [N_IN];
   logic signed [DATA_W-1:0] r_bias;
   logic signed [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]         r_count;
   logic                     r_relu;

   logic                     w_x_fire;
   logic                     w_last;
   logic                     w_cfg_hit;
   logic signed [DATA_W-1:0] w_weight;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [DATA_W-1:0] w_y;

   // Handshakes are derived from the state register, never from outputs.
   assign w_x_fire  = x_valid && (r_state == ACCUM);
   assign w_last    = (r_count == CNT_W'(N_IN - 1));
   assign w_cfg_hit = ({1'b0, cfg_addr} < CNT_W'(N_IN));
   assign w_weight  = r_weights[r_count[IDX_W-1:0]];
   assign w_prod    = PROD_W'(x_data) * PROD_W'(w_weight);

   round_sat_relu #(
      .SHIFT (SHIFT)
   ) u_round_sat_relu (
      .i_acc  (r_acc),
      .i_relu (r_relu),
      .o_y    (w_y)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and status outputs.
   always_comb begin
      w_next_state = r_state;
      busy         = 1'b1;
      x_ready      = 1'b0;
      y_valid      = 1'b0;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_next_state = ACCUM;
            end
         end
         ACCUM: begin
            x_ready = 1'b1;
            if (w_x_fire && w_last) begin
               w_next_state = FINISH;
            end
         end
         FINISH: begin
            w_next_state = OUT;
         end
         OUT: begin
            y_valid = 1'b1;
            if (y_ready) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Configuration, accumulation and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the weight array is a handful of flops, so it is reset with
         // everything else; an aborted run must not see stale weights.
         for (int i = 0; i < N_IN; i++) begin
            r_weights[i] <= '0;
         end
         r_bias  <= '0;
         r_acc   <= '0;
         r_count <= '0;
         r_relu  <= 1'b0;
         y_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cfg_we && w_cfg_hit) begin
                  r_weights[cfg_addr[IDX_W-1:0]] <= cfg_wdata;
               end
               if (bias_we) begin
                  r_bias <= bias_wdata;
               end
               if (start) begin
                  r_acc   <= ACC_W'(r_bias) <<< SHIFT;
                  r_count <= '0;
                  r_relu  <= relu_en;
               end
            end
            ACCUM: begin
               if (w_x_fire) begin
                  r_acc   <= r_acc + ACC_W'(w_prod);
                  r_count <= r_count + CNT_W'(1);
               end
            end
            FINISH: begin
               y_data <= w_y;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
